// File: rtl/lsr_window_feeder.sv
// Streaming front end for the LSR2 line fitter. It keeps the newest DATA_SIZE
// samples in a shift window, pulses start when a window is ready, and freezes
// the window (back-pressuring the source) until the fitter reports fit_done.
module lsr_window_feeder #(
   parameter  int DATA_SIZE = 7,
   parameter  int DATA_W    = 16,
   parameter  int CNT_W     = 16,
   localparam int FL_W      = $clog2(DATA_SIZE + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_in,
   output logic              sample_ready,
   input  logic [CNT_W-1:0]  shift,
   input  logic              fit_done,
   output logic [DATA_W-1:0] window [DATA_SIZE],
   output logic              start,
   output logic [FL_W-1:0]   fill_level,
   output logic              overrun,
   output logic [CNT_W-1:0]  win_count
);

   typedef enum logic [1:0] {S_FILL, S_WAIT_FIT, S_STREAM} state_t;

   state_t             r_state, w_state_nxt;
   logic [DATA_W-1:0]  r_win [DATA_SIZE];
   logic [FL_W-1:0]    r_fill;
   logic [CNT_W-1:0]   r_hop;
   logic [CNT_W-1:0]   r_eff_shift;
   logic               r_start;
   logic               r_overrun;
   logic [CNT_W-1:0]   r_win_count;
   logic               w_ready;
   logic               w_acc;
   logic               w_emit;

   // The window is frozen only while the fitter owns it.
   assign w_ready      = (r_state != S_WAIT_FIT);
   // Flush wins over acceptance: a sample offered in the flush cycle is dropped.
   assign w_acc        = sample_valid & w_ready & ~flush;
   // Held low while in reset so the source sees no readiness until release.
   assign sample_ready = rst_n & w_ready;

   assign window       = r_win;
   assign start        = r_start;
   assign fill_level   = r_fill;
   assign overrun      = r_overrun;
   assign win_count    = r_win_count;

   // Next-state decode; w_emit marks the accept that completes a window.
   always_comb begin
      w_state_nxt = r_state;
      w_emit      = 1'b0;
      case (r_state)
         S_FILL: begin
            if (w_acc && r_fill == FL_W'(DATA_SIZE - 1)) begin
               w_emit      = 1'b1;
               w_state_nxt = S_WAIT_FIT;
            end
         end
         S_WAIT_FIT: begin
            if (fit_done) w_state_nxt = S_STREAM;
         end
         S_STREAM: begin
            if (w_acc && (r_hop + CNT_W'(1)) == r_eff_shift) begin
               w_emit      = 1'b1;
               w_state_nxt = S_WAIT_FIT;
            end
         end
         default: w_state_nxt = S_FILL;
      endcase
   end

   // Control state: FSM, fill/hop counters, start pulse, sticky overrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_FILL;
         r_fill      <= '0;
         r_hop       <= '0;
         r_eff_shift <= CNT_W'(1);
         r_start     <= 1'b0;
         r_overrun   <= 1'b0;
         r_win_count <= '0;
      end else if (flush) begin
         // win_count survives a flush; the abandoned window gets no start.
         r_state     <= S_FILL;
         r_fill      <= '0;
         r_hop       <= '0;
         r_start     <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_start <= w_emit;
         if (w_emit) r_win_count <= r_win_count + CNT_W'(1);
         if (sample_valid && !w_ready) r_overrun <= 1'b1;
         if (w_acc && r_fill != FL_W'(DATA_SIZE)) r_fill <= r_fill + FL_W'(1);
         if (r_state == S_WAIT_FIT && fit_done) begin
            // Hop size is sampled only here, so mid-stream changes wait a window.
            r_hop       <= '0;
            r_eff_shift <= (shift == '0) ? CNT_W'(1) : shift;
         end else if (r_state == S_STREAM && w_acc) begin
            r_hop <= r_hop + CNT_W'(1);
         end
      end
   end

   // Sample window: oldest at [0], newest enters at [DATA_SIZE-1].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DATA_SIZE; k++) r_win[k] <= '0;
      end else if (flush) begin
         for (int k = 0; k < DATA_SIZE; k++) r_win[k] <= '0;
      end else if (w_acc) begin
         for (int k = 0; k < DATA_SIZE - 1; k++) r_win[k] <= r_win[k+1];
         r_win[DATA_SIZE-1] <= sample_in;
      end
   end

endmodule

// File: tb/tb_lsr_window_feeder.sv
// Directed bench for lsr_window_feeder: fill, hop, back-pressure, hop sizes,
// flush, asynchronous reset and bit-exact sign handling.
module tb_lsr_window_feeder;

   localparam int DS = 7;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        sample_valid = 1'b0;
   logic [15:0] sample_in = '0;
   logic        sample_ready;
   logic [15:0] shift = 16'd3;
   logic        fit_done = 1'b0;
   logic [15:0] window [DS];
   logic        start;
   logic [2:0]  fill_level;
   logic        overrun;
   logic [15:0] win_count;

   logic [15:0] exp_w [DS];
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   lsr_window_feeder #(.DATA_SIZE(DS), .DATA_W(16), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .sample_valid(sample_valid), .sample_in(sample_in), .sample_ready(sample_ready),
      .shift(shift), .fit_done(fit_done), .window(window), .start(start),
      .fill_level(fill_level), .overrun(overrun), .win_count(win_count)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic chk_win(input string tag);
      for (int k = 0; k < DS; k++)
         chk($sformatf("%s[%0d]", tag, k), {16'h0, window[k]}, {16'h0, exp_w[k]});
   endtask

   // One accepted sample: drive at negedge, release just after the edge.
   task automatic send(input logic [15:0] v);
      @(negedge clk);
      sample_valid = 1'b1;
      sample_in    = v;
      @(posedge clk);
      #1 sample_valid = 1'b0;
   endtask

   // fit_done pulse for one edge, with the hop size to latch.
   task automatic fit(input logic [15:0] s);
      @(negedge clk);
      shift    = s;
      fit_done = 1'b1;
      @(posedge clk);
      #1 fit_done = 1'b0;
   endtask

   initial begin
      #3;
      chk("rst_start", start, 0);
      chk("rst_fill", fill_level, 0);
      chk("rst_wc", win_count, 0);
      chk("rst_ready", sample_ready, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_ready", sample_ready, 1);

      // Fill 1..7 with shift=3
      for (int i = 1; i <= 7; i++) send(16'(i));
      @(negedge clk);
      chk("fill_start", start, 1);
      chk("fill_ready", sample_ready, 0);
      chk("fill_level", fill_level, 7);
      chk("fill_wc", win_count, 1);
      exp_w = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
      chk_win("fill_win");
      @(negedge clk);
      chk("start_1cyc", start, 0);

      // Hop of 3: fit_done two cycles after start
      fit(16'd3);
      send(16'd8);
      send(16'd9);
      @(negedge clk);
      chk("hop_nostart", start, 0);
      send(16'd10);
      @(negedge clk);
      chk("hop_start", start, 1);
      chk("hop_wc", win_count, 2);
      exp_w = '{16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10};
      chk_win("hop_win");

      // Back-pressure: -5 offered during WAIT_FIT
      @(negedge clk);
      sample_valid = 1'b1;
      sample_in    = 16'hFFFB;
      @(negedge clk);
      chk("bp_overrun", overrun, 1);
      chk("bp_hold", window[6], 16'd10);
      chk("bp_ready", sample_ready, 0);
      shift    = 16'd0;
      fit_done = 1'b1;
      @(posedge clk);
      #1 fit_done = 1'b0;
      @(posedge clk);
      #1 sample_valid = 1'b0;
      @(negedge clk);
      chk("bp_accept", window[6], 16'hFFFB);
      chk("bp_prev", window[5], 16'd10);
      chk("s0_start", start, 1);
      chk("bp_sticky", overrun, 1);
      chk("bp_wc", win_count, 3);

      // shift=0 behaves as 1
      fit(16'd0);
      send(16'd11);
      @(negedge clk);
      chk("s0_start2", start, 1);
      chk("s0_wc", win_count, 4);

      // shift=10 > DATA_SIZE
      fit(16'd10);
      for (int i = 11; i <= 19; i++) send(16'(i));
      @(negedge clk);
      chk("s10_nostart", start, 0);
      send(16'd20);
      @(negedge clk);
      chk("s10_start", start, 1);
      chk("s10_wc", win_count, 5);
      exp_w = '{16'd14, 16'd15, 16'd16, 16'd17, 16'd18, 16'd19, 16'd20};
      chk_win("s10_win");

      // fit_done in the same cycle as start, hop 1
      shift    = 16'd1;
      fit_done = 1'b1;
      @(posedge clk);
      #1 fit_done = 1'b0;
      send(16'd21);
      @(negedge clk);
      chk("same_cyc_start", start, 1);
      chk("same_cyc_win", window[6], 16'd21);
      chk("same_cyc_wc", win_count, 6);

      // Flush during WAIT_FIT with a sample offered
      flush        = 1'b1;
      sample_valid = 1'b1;
      sample_in    = 16'd99;
      @(posedge clk);
      #1 flush = 1'b0;
      sample_valid = 1'b0;
      @(negedge clk);
      chk("fl_fill", fill_level, 0);
      chk("fl_overrun", overrun, 0);
      chk("fl_start", start, 0);
      chk("fl_ready", sample_ready, 1);
      chk("fl_wc", win_count, 6);
      exp_w = '{default: 16'd0};
      chk_win("fl_win");
      for (int i = 1; i <= 6; i++) send(16'(i));
      @(negedge clk);
      chk("fl_6_start", start, 0);
      chk("fl_6_fill", fill_level, 6);
      send(16'd7);
      @(negedge clk);
      chk("fl_7_start", start, 1);
      chk("fl_7_wc", win_count, 7);

      // Sign/width pass-through with hop 2
      fit(16'd2);
      send(16'h8000);
      send(16'h7FFF);
      @(negedge clk);
      chk("sg_start", start, 1);
      chk("sg_w4", window[4], 16'd7);
      chk("sg_w5", window[5], 16'h8000);
      chk("sg_w6", window[6], 16'h7FFF);

      // Asynchronous reset mid-stream
      fit(16'd3);
      send(16'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_start", start, 0);
      chk("ar_fill", fill_level, 0);
      chk("ar_wc", win_count, 0);
      chk("ar_overrun", overrun, 0);
      chk("ar_ready", sample_ready, 0);
      chk("ar_w6", window[6], 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ar_rel_ready", sample_ready, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lsr_window_feeder.md
Name: lsr_window_feeder

Overview:
- Streaming front end for the LSR2 gradient-descent line fitter.
- Accepts one signed 16-bit sample per valid/ready handshake and keeps the most recent DATA_SIZE samples in a shift window.
- Pulses start to the fitter each time a full window is ready, then every `shift` new samples after that.
- Freezes the window and back-pressures the source while the fitter runs, until fit_done.

Parameters:
- DATA_SIZE, 7: window length; must match the fitter's DATA_SIZE.
- DATA_W, 16: sample width, signed two's complement.
- CNT_W, 16: width of the shift input and of win_count.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous clear of the window and fill state.
- sample_valid, input, 1: source has a sample on sample_in.
- sample_in, input, DATA_W: signed sample.
- sample_ready, output, 1: block accepts a sample this cycle.
- shift, input, CNT_W: hop size in samples; 0 is treated as 1.
- fit_done, input, 1: fitter finished with the current window (level or pulse).
- window, output, DATA_W x DATA_SIZE: unpacked array; [0] is the oldest sample, [DATA_SIZE-1] the newest.
- start, output, 1: one-cycle pulse, window valid and stable.
- fill_level, output, clog2(DATA_SIZE+1): samples held, saturates at DATA_SIZE.
- overrun, output, 1: sticky; a sample was offered while sample_ready=0.
- win_count, output, CNT_W: windows emitted, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All window entries, start, fill_level, overrun and win_count = 0.
  - State = FILL; sample_ready = 1 once reset is released.
- Acceptance: a sample is accepted at a rising edge with sample_valid & sample_ready. On accept:
  - window[k] <= window[k+1] for k < DATA_SIZE-1.
  - window[DATA_SIZE-1] <= sample_in.
- State FILL:
  - sample_ready = 1; fill_level increments on each accept.
  - The accept that brings fill_level to DATA_SIZE sets start=1 for the following cycle and moves to WAIT_FIT.
- State WAIT_FIT:
  - sample_ready = 0; window holds.
  - fit_done=1 in any cycle, including the cycle start is high: at the next edge go to STREAM, clear hop_cnt, and latch eff_shift = max(shift,1).
- State STREAM:
  - sample_ready = 1; each accept increments hop_cnt.
  - The accept where hop_cnt+1 == eff_shift sets start=1 next cycle and moves to WAIT_FIT.
  - eff_shift > DATA_SIZE is legal: the discarded samples still shift through.
- start:
  - Registered; high for exactly one cycle.
  - window already holds the new contents during that cycle and stays frozen until the WAIT_FIT exit edge.
  - win_count increments on the same edge that asserts start.
- fit_done is ignored in FILL and STREAM.
- Changes to shift take effect only at the next WAIT_FIT->STREAM transition.
- overrun:
  - Set at any edge with sample_valid=1 and sample_ready=0; the sample is dropped.
  - Cleared only by rst_n or flush.
- flush (highest synchronous priority):
  - Next edge: window = 0, fill_level = 0, hop_cnt = 0, overrun = 0, start = 0, state FILL.
  - A sample presented in the flush cycle is not accepted.
  - win_count is retained.
- Reset or flush mid-WAIT_FIT abandons the window; no start for it is re-issued.
- No arithmetic on samples: values are passed bit-exact, including sign.
- Latency: last accept edge -> start high one cycle later.

Test Plan:
- Fill: reset, feed 1..7 back-to-back with shift=3.
  - start high the cycle after the 7th accept; window = {1,2,3,4,5,6,7}.
  - sample_ready drops the same cycle; fill_level = 7; win_count = 1.
- Hop: pulse fit_done two cycles after start, then feed 8, 9, 10.
  - start follows the accept of 10; window = {4,5,6,7,8,9,10}; win_count = 2.
- Back-pressure: hold sample_valid=1 with value -5 during WAIT_FIT.
  - overrun = 1; window unchanged.
  - -5 is accepted once fit_done arrives; overrun stays 1 until flush.
- shift=0 and shift=10 after the first window:
  - shift=0: start after every single accept.
  - shift=10: start after 10 accepts; window = last 7 samples (e.g. 14..20 after feeding 11..20).
- Flush/reset:
  - Assert flush during WAIT_FIT: fill_level = 0, window all 0, no start; 7 more accepts are required for the next start.
  - Assert rst_n=0 mid-stream, asynchronously between edges: all outputs 0 immediately.
- Sign/width: feed 16'h8000 and 16'h7FFF; both appear bit-exact in window[5] and window[6].
